// File: rtl/fpadd_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
package fpadd_pkg;

  localparam int unsigned FLAGS_W = 3;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Field order gives the port layout {invalid, overflow, inexact}.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  // Aligned significand: hidden bit, fraction, guard, round, sticky.
  function automatic int unsigned ext_width(input int unsigned man_w);
    return man_w + 4;
  endfunction

  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 1;
  endfunction

  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic man_zero);
    if (exp_zero) return CLS_ZERO;
    if (!exp_ones) return CLS_NORM;
    if (man_zero) return CLS_INF;
    return CLS_NAN;
  endfunction

  // Canonical quiet NaN {0, all ones, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i + 1 >= man_w) && (i < man_w + exp_w)) v[6'(i)] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the highest set bit is the last to write.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_pipe.sv
// Three-stage pipelined IEEE-style adder/subtractor with RNE rounding,
// special-value handling, valid/ready flow control and a pass-through tag.
module fpadd_pipe
  import fpadd_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_sub,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [FLAGS_W-1:0]       out_flags
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned EXT_W = ext_width(MAN_W);
  localparam int unsigned SH_W  = 2 * EXT_W;
  localparam int unsigned EW1   = EXP_W + 1;
  localparam int unsigned LZ_W  = $clog2(EXT_W + 1);
  localparam int unsigned NW    = (EW1 > LZ_W) ? EW1 : LZ_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = W'(qnan_bits(EXP_W, MAN_W));

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  fp_class_e        a_cls, b_cls;

  assign {a_s, a_e, a_m} = in_a;
  assign b_s   = in_b[W-1] ^ in_sub;
  assign b_e   = in_b[W-2:MAN_W];
  assign b_m   = in_b[MAN_W-1:0];
  assign a_cls = classify(&a_e, a_e == '0, a_m == '0);
  assign b_cls = classify(&b_e, b_e == '0, b_m == '0);

  logic             a_big, big_s;
  logic [EXP_W-1:0] big_e, small_e, e_diff;
  logic [MAN_W-1:0] big_m, small_m;
  logic [EXT_W-1:0] big_sig, small_al;
  logic [SH_W-1:0]  small_sh;
  logic             force1;
  logic [W-1:0]     force_res1;
  fp_flags_t        force_flags1;

  always_comb begin
    force1       = 1'b0;
    force_res1   = '0;
    force_flags1 = '0;
    a_big   = {a_e, a_m} >= {b_e, b_m};
    big_s   = a_big ? a_s : b_s;
    big_e   = a_big ? a_e : b_e;
    big_m   = a_big ? a_m : b_m;
    small_e = a_big ? b_e : a_e;
    small_m = a_big ? b_m : a_m;
    e_diff  = big_e - small_e;
    big_sig = {1'b1, big_m, 3'b000};
    small_sh = {1'b1, small_m, 3'b000, EXT_W'(0)} >> e_diff;
    // Far-out operands collapse into the sticky bit alone.
    if (32'(e_diff) >= MAN_W + 3) small_al = EXT_W'(1);
    else small_al = {small_sh[SH_W-1:EXT_W+1], small_sh[EXT_W] | (|small_sh[EXT_W-1:0])};

    if (a_cls == CLS_NAN || b_cls == CLS_NAN ||
        (a_cls == CLS_INF && b_cls == CLS_INF && a_s != b_s)) begin
      force1               = 1'b1;
      force_res1           = QNAN;
      force_flags1.invalid = 1'b1;
    end else if (a_cls == CLS_INF) begin
      force1     = 1'b1;
      force_res1 = in_a;
    end else if (b_cls == CLS_INF) begin
      force1     = 1'b1;
      force_res1 = {b_s, b_e, b_m};
    end else if (a_cls == CLS_ZERO && b_cls == CLS_ZERO) begin
      force1     = 1'b1;
      force_res1 = {a_s & b_s, (W-1)'(0)};
    end else if (a_cls == CLS_ZERO) begin
      force1     = 1'b1;
      force_res1 = {b_s, b_e, b_m};
    end else if (b_cls == CLS_ZERO) begin
      force1     = 1'b1;
      force_res1 = in_a;
    end
  end

  logic             s1_valid, s1_force, s1_sign, s1_eff_sub;
  logic [TAG_W-1:0] s1_tag;
  logic [W-1:0]     s1_force_res;
  fp_flags_t        s1_force_flags;
  logic [EXP_W-1:0] s1_exp;
  logic [EXT_W-1:0] s1_big, s1_small;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_tag         <= '0;
      s1_force       <= 1'b0;
      s1_force_res   <= '0;
      s1_force_flags <= '0;
      s1_sign        <= 1'b0;
      s1_eff_sub     <= 1'b0;
      s1_exp         <= '0;
      s1_big         <= '0;
      s1_small       <= '0;
    end else if (adv) begin
      s1_valid       <= in_valid;
      s1_tag         <= in_tag;
      s1_force       <= force1;
      s1_force_res   <= force_res1;
      s1_force_flags <= force_flags1;
      s1_sign        <= big_s;
      s1_eff_sub     <= a_s ^ b_s;
      s1_exp         <= big_e;
      s1_big         <= big_sig;
      s1_small       <= small_al;
    end
  end

  // ---------------- Stage 2: add/subtract and normalise ----------------
  logic [EXT_W:0]   sum2;
  logic [EXT_W-1:0] mag2, norm2;
  logic [EW1-1:0]   exp2, exp_n2;
  logic [LZ_W-1:0]  lz2;
  logic             under2, force2;
  logic [W-1:0]     force_res2;
  fp_flags_t        force_flags2;

  fp_lzc #(.WIDTH(EXT_W), .CNT_W(LZ_W)) u_lzc (
    .value (mag2),
    .count (lz2)
  );

  always_comb begin
    force2       = s1_force;
    force_res2   = s1_force_res;
    force_flags2 = s1_force_flags;
    sum2 = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                      : ({1'b0, s1_big} + {1'b0, s1_small});
    if (!s1_eff_sub && sum2[EXT_W]) begin
      mag2 = {sum2[EXT_W:2], sum2[1] | sum2[0]};
      exp2 = EW1'(s1_exp) + EW1'(1);
    end else begin
      mag2 = sum2[EXT_W-1:0];
      exp2 = EW1'(s1_exp);
    end
    norm2  = mag2 << lz2;
    under2 = NW'(lz2) >= NW'(exp2);
    exp_n2 = EW1'(NW'(exp2) - NW'(lz2));
    if (!s1_force) begin
      if (mag2 == '0) begin
        force2     = 1'b1;
        force_res2 = '0;
      end else if (under2) begin
        force2               = 1'b1;
        force_res2           = {s1_sign, (W-1)'(0)};
        force_flags2.inexact = 1'b1;
      end
    end
  end

  logic             s2_valid, s2_force, s2_sign;
  logic [TAG_W-1:0] s2_tag;
  logic [W-1:0]     s2_force_res;
  fp_flags_t        s2_force_flags;
  logic [EW1-1:0]   s2_exp;
  logic [EXT_W-1:0] s2_man;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid       <= 1'b0;
      s2_tag         <= '0;
      s2_force       <= 1'b0;
      s2_force_res   <= '0;
      s2_force_flags <= '0;
      s2_sign        <= 1'b0;
      s2_exp         <= '0;
      s2_man         <= '0;
    end else if (adv) begin
      s2_valid       <= s1_valid;
      s2_tag         <= s1_tag;
      s2_force       <= force2;
      s2_force_res   <= force_res2;
      s2_force_flags <= force_flags2;
      s2_sign        <= s1_sign;
      s2_exp         <= exp_n2;
      s2_man         <= norm2;
    end
  end

  // ---------------- Stage 3: round to nearest even, pack ----------------
  logic             g3, r3, st3, rnd3;
  logic [MAN_W+1:0] mant3;
  logic [EW1-1:0]   exp3;
  logic [MAN_W-1:0] frac3;
  logic [W-1:0]     res3;
  fp_flags_t        flags3;

  always_comb begin
    g3    = s2_man[2];
    r3    = s2_man[1];
    st3   = s2_man[0];
    rnd3  = g3 & (r3 | st3 | s2_man[3]);
    mant3 = {1'b0, s2_man[EXT_W-1:3]} + (MAN_W+2)'(rnd3);
    if (mant3[MAN_W+1]) begin
      exp3  = s2_exp + EW1'(1);
      frac3 = mant3[MAN_W:1];
    end else begin
      exp3  = s2_exp;
      frac3 = mant3[MAN_W-1:0];
    end
    flags3         = '0;
    flags3.inexact = g3 | r3 | st3;
    res3           = {s2_sign, exp3[EXP_W-1:0], frac3};
    if (s2_force) begin
      res3   = s2_force_res;
      flags3 = s2_force_flags;
    end else if (exp3 >= EW1'(EXP_ONES)) begin
      res3            = {s2_sign, EXP_ONES, MAN_W'(0)};
      flags3.overflow = 1'b1;
      flags3.inexact  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      out_valid  <= s2_valid;
      out_result <= res3;
      out_tag    <= s2_tag;
      out_flags  <= flags3;
    end
  end

endmodule

// File: tb/tb_fpadd_pipe.sv
// Scoreboard bench for fpadd_pipe: FP32 instance plus an FP16 instance.
module tb_fpadd_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag;
  logic [2:0]  out_flags;

  logic        h_valid, h_ready, h_sub, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_out_result;
  logic [3:0]  h_tag, h_out_tag;
  logic [2:0]  h_out_flags;

  fpadd_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  fpadd_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(h_valid), .in_ready(h_ready),
    .in_a(h_a), .in_b(h_b), .in_sub(h_sub), .in_tag(h_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_result(h_out_result),
    .out_tag(h_out_tag), .out_flags(h_out_flags)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [2:0]  flags;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  exp_t q[$], q16[$];
  exp_t mon_e, mon16_e;
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // FP32 output monitor: every transfer must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h tag %h, required no output", out_result, out_tag);
      end else begin
        mon_e = q.pop_front();
        check("result", out_result, mon_e.res);
        check("tag", 32'(out_tag), 32'(mon_e.tag));
        check("flags", 32'(out_flags), 32'(mon_e.flags));
      end
    end
  end

  // Stall monitor: held output must not move and input side must be blocked.
  bit          hold_prev = 1'b0;
  logic [31:0] held_res;
  logic [3:0]  held_tag;
  always @(negedge clk) begin
    if (!reset && out_valid && !out_ready) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (hold_prev) begin
        check("stall_result_stable", out_result, held_res);
        check("stall_tag_stable", 32'(out_tag), 32'(held_tag));
      end
      hold_prev = 1'b1;
      held_res  = out_result;
      held_tag  = out_tag;
    end else begin
      hold_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && h_out_valid && h_out_ready) begin
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output16: got %h, required no output", h_out_result);
      end else begin
        mon16_e = q16.pop_front();
        check("result16", 32'(h_out_result), mon16_e.res);
        check("tag16", 32'(h_out_tag), 32'(mon16_e.tag));
        check("flags16", 32'(h_out_flags), 32'(mon16_e.flags));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [3:0] tag, input logic [31:0] res,
                      input logic [2:0] flags, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", n);
    end else if (push) begin
      q.push_back(exp_t'({res, tag, flags}));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [3:0] tag, input logic [15:0] res, input logic [2:0] flags);
    int n = 0;
    h_valid = 1'b1;
    h_a     = a;
    h_b     = b;
    h_sub   = sub;
    h_tag   = tag;
    while (!h_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!h_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout16: in_ready 0 for %0d cycles, required 1", n);
    end else begin
      q16.push_back(exp_t'({16'h0, res, tag, flags}));
    end
    @(negedge clk);
    h_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(q.size() + q16.size()), 32'd0);
  endtask

  task automatic latency_check(input string name);
    check({name, "_c1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_c2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_c3"}, 32'(out_valid), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    h_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_tag = '0; h_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_out_flags", 32'(out_flags), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    send(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 3'b000, 1'b1);
    latency_check("latency");

    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 4'd1,  32'h00000000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 4'd2,  32'h3F800000, 3'b001});
    vecs.push_back('{32'h3F800000, 32'h33C00000, 1'b0, 4'd3,  32'h3F800001, 3'b001});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd4,  32'h7F800000, 3'b011});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 4'd5,  32'h7FC00000, 3'b100});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 4'd6,  32'h7FC00000, 3'b100});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 4'd7,  32'h7FC00000, 3'b100});
    vecs.push_back('{32'h3F800000, 32'hFF800000, 1'b0, 4'd8,  32'hFF800000, 3'b000});
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 4'd9,  32'h00000000, 3'b000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 4'd10, 32'h80000000, 3'b000});
    vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, 4'd11, 32'h80000000, 3'b001});
    vecs.push_back('{32'h3F800000, 32'h00800000, 1'b0, 4'd12, 32'h3F800000, 3'b001});
    vecs.push_back('{32'h40490FDB, 32'h00000000, 1'b0, 4'd13, 32'h40490FDB, 3'b000});
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].tag, vecs[i].res, vecs[i].flags, 1'b1);
    drain();

    // Back-to-back stream with a five-cycle consumer stall.
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 3'b000, 1'b1);
        send(32'h40000000, 32'h40000000, 1'b0, 4'd2, 32'h40800000, 3'b000, 1'b1);
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd3, 32'h40000000, 3'b000, 1'b1);
        send(32'h3F800000, 32'hBF000000, 1'b0, 4'd4, 32'h3F000000, 3'b000, 1'b1);
        send(32'h3F800000, 32'h00000000, 1'b0, 4'd5, 32'h3F800000, 3'b000, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 4'd6, 32'h80000000, 3'b000, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight; neither may ever surface.
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd9,  32'h0, 3'b000, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, 4'd10, 32'h0, 3'b000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_result", out_result, 32'd0);
    check("midreset_out_tag", 32'(out_tag), 32'd0);
    check("midreset_out_flags", 32'(out_flags), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    send(32'h3F800000, 32'hBF800000, 1'b1, 4'd7, 32'h40000000, 3'b000, 1'b1);
    latency_check("post_reset_latency");
    drain();

    send16(16'h3C00, 16'h3C00, 1'b0, 4'd1, 16'h4000, 3'b000);
    send16(16'h7BFF, 16'h7BFF, 1'b0, 4'd2, 16'h7C00, 3'b011);
    send16(16'h3C00, 16'h3C00, 1'b1, 4'd3, 16'h0000, 3'b000);
    send16(16'h4000, 16'h3C00, 1'b0, 4'd4, 16'h4200, 3'b000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpadd_pipe.md
Name: fpadd_pipe

Overview:
- Parametrised, 3-stage pipelined floating-point adder/subtractor for any EXP_W/MAN_W IEEE-style format. FP32 is the default.
- Successor to the single-cycle FP32 adder. Adds a subtract mode, round-to-nearest-even, special-value handling, valid/ready flow control and a pass-through tag.
- Sits between the operand source and the result consumer in the FPU datapath. Sustains one operation per cycle.

Parameters:
- EXP_W, 8: exponent field width, bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- Derived constant: W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  adder accepts operands this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  0: A+B, 1: A-B (B sign inverted at unpack).
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  rounded sum.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  3  {invalid, overflow, inexact}.

Behaviour:
- Reset: synchronous; clk and reset as above.
  - All stage valid bits clear. out_valid=0, out_result=0, out_tag=0, out_flags=0. in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Flow control:
  - adv = !out_valid || out_ready; in_ready = adv.
  - Pipeline is a single-enable shift of 3 stages. Each stage holds a valid bit and advances only when adv=1.
  - Bubbles are not collapsed.
  - While out_valid && !out_ready, out_result/out_tag/out_flags hold stable and all stages freeze.
  - Accept occurs on in_valid && in_ready. Latency is exactly 3 cycles from accept to out_valid when never stalled. Throughput is 1/cycle.
- Stage 1 (unpack/align):
  - Apply in_sub. Treat exp==0 as signed zero (subnormals flush to zero, inexact not set).
  - Classify inf/NaN (exp all ones).
  - Swap so that the larger magnitude is first, compared on {exp, man}.
  - Build MAN_W+1 significands with the hidden 1. Right-shift the smaller by the exponent difference into a MAN_W+4 field holding guard, round and sticky bits.
  - Shift amounts of MAN_W+3 or more leave only sticky.
- Stage 2 (add/normalise):
  - Signs equal: add; on carry-out, shift right by 1 (OR into sticky) and increment exponent.
  - Signs differ: subtract.
  - Leading-zero count, then left-normalise and decrement exponent.
  - A zero difference yields exact +0.
  - Normalising below exp=1 flushes to signed zero with inexact=1.
- Stage 3 (round/pack):
  - Round to nearest, ties to even, using guard/round/sticky. Mantissa round-up overflow increments exponent.
  - Exponent reaching all ones gives ±inf with overflow=1 and inexact=1.
  - inexact = any of guard/round/sticky set before rounding.
- Special values, resolved in stage 1 and carried as a forced result:
  - Any NaN operand, or inf + (-inf) after in_sub, gives canonical qNaN {0, all ones, 1 followed by zeros} with invalid=1.
  - Otherwise, if either operand is inf, the result is that inf.
  - x + 0 returns x exactly.
  - (+0)+(-0) = +0; (-0)+(-0) = -0.
  - x + (-x) = +0.

Decomposition:
- Package fpadd_pkg: EXP_W/MAN_W-derived widths, bias, class encoding (ZERO/NORM/INF/NAN), flag bit indices, qNaN constant function.
- One sub-module, fp_lzc (parametrised leading-zero counter, width MAN_W+4), instantiated in stage 2.
- Alignment shifter and rounder are inline.

Test Plan:
- Latency: 0x3F800000 + 0x40000000, in_sub=0, in_tag=5, out_ready=1 -> out_valid exactly 3 cycles after accept; 0x40400000, tag 5, flags 000.
- Cancellation and rounding:
  - 0x3F800000 - 0x3F800000 -> 0x00000000, flags 000.
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33C00000 -> 0x3F800001, inexact=1.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 011.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Backpressure: stream 6 back-to-back ops, out_ready=0 from cycle 4 for 5 cycles.
  - in_ready=0 while out_valid is held; out_result stable.
  - All 6 results emerge in order with correct tags; none dropped or duplicated.
- Reset mid-flight: 2 ops in pipeline, assert reset 1 cycle.
  - Next cycle: out_valid=0, outputs 0, in_ready=1.
  - No stale result ever appears; a new op completes in 3 cycles.
- Parametrisation: EXP_W=5, MAN_W=10 (FP16): 0x3C00 + 0x3C00 -> 0x4000; 0x7BFF + 0x7BFF -> 0x7C00, overflow=1.
